// File: rtl/carbonio_timer_bank_if.sv
// Register-side bundle for the CarbonIO timer bank: write strobes and data from the
// register decoder, stored/live values back to it, and the aggregated interrupt.
interface carbonio_timer_bank_if #(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TICK_W     = 64,
  parameter int unsigned PRESCALE_W = 8
);
  logic                                  enable;
  logic                                  prescale_we;
  logic [PRESCALE_W-1:0]                 prescale_wdata;
  logic [PRESCALE_W-1:0]                 prescale_q;
  logic [TICK_W-1:0]                     tick_counter;
  logic                                  snap_req;
  logic [TICK_W-1:0]                     tick_snapshot;
  logic [NUM_TIMERS-1:0]                 load_we;
  logic [NUM_TIMERS-1:0][CNT_W-1:0]      load_wdata;
  logic [NUM_TIMERS-1:0]                 cmp_we;
  logic [NUM_TIMERS-1:0][CNT_W-1:0]      cmp_wdata;
  logic [NUM_TIMERS-1:0]                 ctrl_we;
  logic [NUM_TIMERS-1:0][7:0]            ctrl_wdata;
  logic [NUM_TIMERS-1:0][1:0]            status_clr;
  logic [NUM_TIMERS-1:0][CNT_W-1:0]      load_q;
  logic [NUM_TIMERS-1:0][CNT_W-1:0]      cmp_q;
  logic [NUM_TIMERS-1:0][7:0]            ctrl_q;
  logic [NUM_TIMERS-1:0][CNT_W-1:0]      value_q;
  logic [NUM_TIMERS-1:0]                 expired_q;
  logic [NUM_TIMERS-1:0]                 match_q;
  logic [NUM_TIMERS-1:0]                 expired_pulse;
  logic                                  irq;

  modport master (
    output enable, prescale_we, prescale_wdata, snap_req,
           load_we, load_wdata, cmp_we, cmp_wdata, ctrl_we, ctrl_wdata, status_clr,
    input  prescale_q, tick_counter, tick_snapshot, load_q, cmp_q, ctrl_q,
           value_q, expired_q, match_q, expired_pulse, irq
  );

  modport slave (
    input  enable, prescale_we, prescale_wdata, snap_req,
           load_we, load_wdata, cmp_we, cmp_wdata, ctrl_we, ctrl_wdata, status_clr,
    output prescale_q, tick_counter, tick_snapshot, load_q, cmp_q, ctrl_q,
           value_q, expired_q, match_q, expired_pulse, irq
  );
endinterface

// File: rtl/carbonio_timer_bank.sv
// CarbonIO timer bank: shared prescaler, monotonic tick counter with snapshot latch,
// and NUM_TIMERS reloadable down-counters with expiry/match status and interrupt.
module carbonio_timer_bank #(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TICK_W     = 64,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  carbonio_timer_bank_if.slave  bus
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [TICK_W-1:0]     tick_cnt_r;
  logic [TICK_W-1:0]     snapshot_r;
  logic                  tick;

  // A divisor write restarts the division window, so no tick may escape that cycle.
  assign tick = bus.enable & ~bus.prescale_we & (pre_cnt == prescale_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      prescale_r <= '0;
      tick_cnt_r <= '0;
      snapshot_r <= '0;
    end else begin
      if (bus.prescale_we) begin
        prescale_r <= bus.prescale_wdata;
        pre_cnt    <= '0;
      end else if (bus.enable) begin
        pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
      end
      if (tick)
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      if (bus.snap_req)
        snapshot_r <= tick_cnt_r;
    end
  end

  logic [NUM_TIMERS-1:0][CNT_W-1:0] load_r;
  logic [NUM_TIMERS-1:0][CNT_W-1:0] cmp_r;
  logic [NUM_TIMERS-1:0][CNT_W-1:0] value_r;
  logic [NUM_TIMERS-1:0]            run_r;
  logic [NUM_TIMERS-1:0]            auto_r;
  logic [NUM_TIMERS-1:0]            ie_exp_r;
  logic [NUM_TIMERS-1:0]            ie_match_r;
  logic [NUM_TIMERS-1:0]            expired_r;
  logic [NUM_TIMERS-1:0]            match_r;
  logic [NUM_TIMERS-1:0]            pulse_r;

  logic [NUM_TIMERS-1:0]            reload_now;
  logic [NUM_TIMERS-1:0]            step;
  logic [NUM_TIMERS-1:0]            at_zero;
  logic [NUM_TIMERS-1:0]            expire_set;
  logic [NUM_TIMERS-1:0]            match_set;
  logic [NUM_TIMERS-1:0][CNT_W-1:0] reload_val;
  logic [NUM_TIMERS-1:0][7:0]       ctrl_view;

  always_comb begin
    reload_now = '0;
    step       = '0;
    at_zero    = '0;
    expire_set = '0;
    match_set  = '0;
    reload_val = '0;
    ctrl_view  = '0;
    for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
      reload_now[i] = bus.ctrl_we[i] & bus.ctrl_wdata[i][2];
      // Same-cycle load write is forwarded so reload_now picks up the new value.
      reload_val[i] = bus.load_we[i] ? bus.load_wdata[i] : load_r[i];
      at_zero[i]    = (value_r[i] == '0);
      step[i]       = tick & run_r[i] & ~reload_now[i];
      expire_set[i] = step[i] & at_zero[i];
      // Nonzero value equal to cmp implies cmp != 0, so a zero compare never matches.
      match_set[i]  = step[i] & ~at_zero[i] & (value_r[i] == cmp_r[i]);
      ctrl_view[i]  = {3'b000, ie_match_r[i], ie_exp_r[i], 1'b0, auto_r[i], run_r[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_r     <= '0;
      cmp_r      <= '0;
      value_r    <= '0;
      run_r      <= '0;
      auto_r     <= '0;
      ie_exp_r   <= '0;
      ie_match_r <= '0;
      expired_r  <= '0;
      match_r    <= '0;
      pulse_r    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
        if (bus.load_we[i])
          load_r[i] <= bus.load_wdata[i];
        if (bus.cmp_we[i])
          cmp_r[i] <= bus.cmp_wdata[i];

        if (reload_now[i])
          value_r[i] <= reload_val[i];
        else if (step[i])
          value_r[i] <= at_zero[i] ? (auto_r[i] ? load_r[i] : '0)
                                   : value_r[i] - CNT_W'(1);

        // A control write wins over the one-shot run clear in the same cycle.
        if (bus.ctrl_we[i]) begin
          run_r[i]      <= bus.ctrl_wdata[i][0];
          auto_r[i]     <= bus.ctrl_wdata[i][1];
          ie_exp_r[i]   <= bus.ctrl_wdata[i][3];
          ie_match_r[i] <= bus.ctrl_wdata[i][4];
        end else if (expire_set[i] && !auto_r[i]) begin
          run_r[i] <= 1'b0;
        end

        expired_r[i] <= expire_set[i] | (expired_r[i] & ~bus.status_clr[i][0]);
        match_r[i]   <= match_set[i]  | (match_r[i]   & ~bus.status_clr[i][1]);
        pulse_r[i]   <= expire_set[i];
      end
    end
  end

  assign bus.prescale_q    = prescale_r;
  assign bus.tick_counter  = tick_cnt_r;
  assign bus.tick_snapshot = snapshot_r;
  assign bus.load_q        = load_r;
  assign bus.cmp_q         = cmp_r;
  assign bus.ctrl_q        = ctrl_view;
  assign bus.value_q       = value_r;
  assign bus.expired_q     = expired_r;
  assign bus.match_q       = match_r;
  assign bus.expired_pulse = pulse_r;
  assign bus.irq           = |((expired_r & ie_exp_r) | (match_r & ie_match_r));

endmodule

// File: tb/tb_carbonio_timer_bank.sv
// Self-checking bench for carbonio_timer_bank: directed scenarios plus randomized
// traffic compared against a behavioural model of the timer bank.
module tb_carbonio_timer_bank;
  localparam int NT = 4;
  localparam int CW = 32;
  localparam int TW = 64;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carbonio_timer_bank_if #(.NUM_TIMERS(NT), .CNT_W(CW), .TICK_W(TW), .PRESCALE_W(PW)) bus ();

  carbonio_timer_bank #(.NUM_TIMERS(NT), .CNT_W(CW), .TICK_W(TW), .PRESCALE_W(PW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int unsigned  m_pre, m_div;
  logic [63:0]  m_ticks, m_snap;
  logic [31:0]  m_load[NT], m_cmp[NT], m_val[NT];
  bit           m_run[NT], m_auto[NT], m_iee[NT], m_iem[NT];
  bit           m_exp[NT], m_mat[NT], m_pulse[NT];

  function automatic void model_reset();
    m_pre = 0; m_div = 0; m_ticks = '0; m_snap = '0;
    for (int i = 0; i < NT; i++) begin
      m_load[i] = 0; m_cmp[i] = 0; m_val[i] = 0;
      m_run[i] = 0; m_auto[i] = 0; m_iee[i] = 0; m_iem[i] = 0;
      m_exp[i] = 0; m_mat[i] = 0; m_pulse[i] = 0;
    end
  endfunction

  function automatic bit model_irq();
    bit r = 0;
    for (int i = 0; i < NT; i++)
      r = r | (m_exp[i] & m_iee[i]) | (m_mat[i] & m_iem[i]);
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit tick_now;
    tick_now = bus.enable && !bus.prescale_we && (m_pre == m_div);
    for (int i = 0; i < NT; i++) begin
      bit          forced, fired, hit, stop;
      logic [31:0] nv;
      forced = bus.ctrl_we[i] && bus.ctrl_wdata[i][2];
      fired = 0; hit = 0; stop = 0; nv = m_val[i];
      if (forced)
        nv = bus.load_we[i] ? bus.load_wdata[i] : m_load[i];
      else if (tick_now && m_run[i]) begin
        if (m_val[i] == 0) begin
          fired = 1;
          if (m_auto[i]) nv = m_load[i];
          else stop = 1;
        end else begin
          nv  = m_val[i] - 1;
          hit = (m_val[i] == m_cmp[i]);
        end
      end
      m_val[i] = nv;
      if (bus.ctrl_we[i]) begin
        m_run[i] = bus.ctrl_wdata[i][0]; m_auto[i] = bus.ctrl_wdata[i][1];
        m_iee[i] = bus.ctrl_wdata[i][3]; m_iem[i] = bus.ctrl_wdata[i][4];
      end else if (stop) m_run[i] = 0;
      if (bus.load_we[i]) m_load[i] = bus.load_wdata[i];
      if (bus.cmp_we[i])  m_cmp[i]  = bus.cmp_wdata[i];
      m_exp[i]   = fired || (m_exp[i] && !bus.status_clr[i][0]);
      m_mat[i]   = hit   || (m_mat[i] && !bus.status_clr[i][1]);
      m_pulse[i] = fired;
    end
    if (bus.snap_req) m_snap = m_ticks;
    if (tick_now) m_ticks = m_ticks + 1;
    if (bus.prescale_we) begin
      m_div = bus.prescale_wdata; m_pre = 0;
    end else if (bus.enable)
      m_pre = tick_now ? 0 : m_pre + 1;
  endfunction

  task automatic clear_strobes();
    bus.prescale_we = 0; bus.snap_req = 0;
    bus.load_we = '0; bus.cmp_we = '0; bus.ctrl_we = '0; bus.status_clr = '0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    bus.enable = 0;
    clear_strobes();
    bus.prescale_wdata = '0; bus.load_wdata = '0; bus.cmp_wdata = '0; bus.ctrl_wdata = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.tick_counter !== 64'd0) begin errors++; $display("FAIL reset_tick got=%0d exp=0", bus.tick_counter); end
    checks++; if (bus.tick_snapshot !== 64'd0) begin errors++; $display("FAIL reset_snap got=%0d exp=0", bus.tick_snapshot); end
    checks++; if (bus.prescale_q !== 8'd0) begin errors++; $display("FAIL reset_prescale got=%0d exp=0", bus.prescale_q); end
    checks++; if (bus.value_q !== '0 || bus.ctrl_q !== '0 || bus.load_q !== '0 || bus.cmp_q !== '0) begin
      errors++; $display("FAIL reset_timers value=%h ctrl=%h exp=0", bus.value_q, bus.ctrl_q); end
    checks++; if (bus.expired_q !== '0 || bus.match_q !== '0 || bus.expired_pulse !== '0 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL reset_status exp=%b mat=%b pulse=%b irq=%b", bus.expired_q, bus.match_q, bus.expired_pulse, bus.irq); end
  endtask

  task automatic test_tick_snapshot();
    do_reset();
    bus.enable = 1;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) bus.snap_req = 1;
      cycle();
    end
    checks++; if (bus.tick_counter !== 64'd10) begin errors++; $display("FAIL tick_count got=%0d exp=10", bus.tick_counter); end
    checks++; if (bus.tick_snapshot !== 64'd4) begin errors++; $display("FAIL snapshot got=%0d exp=4", bus.tick_snapshot); end
    for (int c = 0; c < 3; c++) cycle();
    checks++; if (bus.tick_snapshot !== 64'd4 || bus.tick_counter !== 64'd13) begin
      errors++; $display("FAIL snapshot_hold snap=%0d tick=%0d exp=4/13", bus.tick_snapshot, bus.tick_counter); end
  endtask

  task automatic test_prescale();
    do_reset();
    bus.prescale_we = 1; bus.prescale_wdata = 8'd3;
    cycle();
    checks++; if (bus.prescale_q !== 8'd3) begin errors++; $display("FAIL prescale_q got=%0d exp=3", bus.prescale_q); end
    bus.enable = 1;
    for (int c = 0; c < 16; c++) cycle();
    checks++; if (bus.tick_counter !== 64'd4) begin errors++; $display("FAIL prescale_ticks got=%0d exp=4", bus.tick_counter); end
    bus.enable = 0;
    for (int c = 0; c < 5; c++) cycle();
    checks++; if (bus.tick_counter !== 64'd4) begin errors++; $display("FAIL freeze_ticks got=%0d exp=4", bus.tick_counter); end
    bus.enable = 1;
    for (int c = 0; c < 3; c++) cycle();
    checks++; if (bus.tick_counter !== 64'd4) begin errors++; $display("FAIL freeze_precnt got=%0d exp=4", bus.tick_counter); end
    cycle();
    checks++; if (bus.tick_counter !== 64'd5) begin errors++; $display("FAIL resume_tick got=%0d exp=5", bus.tick_counter); end
  endtask

  task automatic test_autoreload();
    logic [31:0] seq [6];
    seq = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1};
    do_reset();
    bus.enable = 1;
    bus.load_we[0] = 1; bus.load_wdata[0] = 32'd3;
    bus.ctrl_we[0] = 1; bus.ctrl_wdata[0] = 8'h0F;
    cycle();
    checks++; if (bus.value_q[0] !== 32'd3 || bus.ctrl_q[0] !== 8'h0B) begin
      errors++; $display("FAIL auto_start value=%0d ctrl=%h exp=3/0b", bus.value_q[0], bus.ctrl_q[0]); end
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.status_clr[0] = 2'b01;
      cycle();
      checks++; if (bus.value_q[0] !== seq[c]) begin errors++; $display("FAIL auto_value step=%0d got=%0d exp=%0d", c, bus.value_q[0], seq[c]); end
      checks++; if (bus.expired_pulse[0] !== (c == 3)) begin errors++; $display("FAIL auto_pulse step=%0d got=%b exp=%b", c, bus.expired_pulse[0], c == 3); end
      checks++; if (bus.irq !== (c == 3 || c == 4)) begin errors++; $display("FAIL auto_irq step=%0d got=%b exp=%b", c, bus.irq, c == 3 || c == 4); end
    end
  endtask

  task automatic test_oneshot();
    int pulses = 0;
    do_reset();
    bus.enable = 1;
    bus.load_we[1] = 1; bus.load_wdata[1] = 32'd2;
    bus.ctrl_we[1] = 1; bus.ctrl_wdata[1] = 8'h05;
    cycle(); cycle(); cycle(); cycle();
    checks++; if (bus.expired_pulse[1] !== 1'b1 || bus.expired_q[1] !== 1'b1) begin
      errors++; $display("FAIL oneshot_expire pulse=%b exp_q=%b exp=1/1", bus.expired_pulse[1], bus.expired_q[1]); end
    checks++; if (bus.ctrl_q[1][0] !== 1'b0 || bus.value_q[1] !== 32'd0) begin
      errors++; $display("FAIL oneshot_stop run=%b value=%0d exp=0/0", bus.ctrl_q[1][0], bus.value_q[1]); end
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bus.expired_pulse[1] !== 1'b0 || bus.value_q[1] !== 32'd0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL oneshot_idle bad_cycles=%0d exp=0", pulses); end
  endtask

  task automatic test_match();
    do_reset();
    bus.enable = 1;
    bus.load_we[2] = 1; bus.load_wdata[2] = 32'd10;
    bus.cmp_we[2] = 1;  bus.cmp_wdata[2] = 32'd6;
    bus.ctrl_we[2] = 1; bus.ctrl_wdata[2] = 8'h15;
    cycle();
    for (int c = 0; c < 4; c++) cycle();
    checks++; if (bus.value_q[2] !== 32'd6 || bus.match_q[2] !== 1'b0 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL match_pre value=%0d match=%b irq=%b exp=6/0/0", bus.value_q[2], bus.match_q[2], bus.irq); end
    bus.status_clr[2] = 2'b10;
    cycle();
    checks++; if (bus.value_q[2] !== 32'd5 || bus.match_q[2] !== 1'b1 || bus.irq !== 1'b1) begin
      errors++; $display("FAIL match_set_beats_clr value=%0d match=%b irq=%b exp=5/1/1", bus.value_q[2], bus.match_q[2], bus.irq); end
    bus.status_clr[2] = 2'b10;
    cycle();
    checks++; if (bus.match_q[2] !== 1'b0 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL match_clear match=%b irq=%b exp=0/0", bus.match_q[2], bus.irq); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.enable = 1;
    bus.load_we[3] = 1; bus.load_wdata[3] = 32'd20;
    bus.ctrl_we[3] = 1; bus.ctrl_wdata[3] = 8'h05;
    cycle(); cycle(); cycle();
    checks++; if (bus.value_q[3] !== 32'd18) begin errors++; $display("FAIL b2b_count got=%0d exp=18", bus.value_q[3]); end
    bus.load_we[3] = 1; bus.load_wdata[3] = 32'h55;
    bus.ctrl_we[3] = 1; bus.ctrl_wdata[3] = 8'h05;
    cycle();
    checks++; if (bus.value_q[3] !== 32'h55 || bus.load_q[3] !== 32'h55) begin
      errors++; $display("FAIL b2b_forward value=%h load=%h exp=55/55", bus.value_q[3], bus.load_q[3]); end
    cycle();
    checks++; if (bus.value_q[3] !== 32'h54) begin errors++; $display("FAIL b2b_resume got=%h exp=54", bus.value_q[3]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++; if (bus.tick_counter !== 64'd0 || bus.value_q !== '0 || bus.irq !== 1'b0) begin
          errors++; $display("FAIL rnd_async_reset tick=%0d value=%h irq=%b exp=0", bus.tick_counter, bus.value_q, bus.irq); end
        #1;
        rst_n = 1;
      end
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.prescale_we = 1; bus.prescale_wdata = 8'($urandom_range(0, 3));
      end
      bus.snap_req = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 19) == 0) begin bus.load_we[i] = 1; bus.load_wdata[i] = $urandom_range(0, 12); end
        if ($urandom_range(0, 19) == 0) begin bus.cmp_we[i] = 1;  bus.cmp_wdata[i]  = $urandom_range(0, 12); end
        if ($urandom_range(0, 24) == 0) begin bus.ctrl_we[i] = 1; bus.ctrl_wdata[i] = 8'($urandom); end
        if ($urandom_range(0, 7) == 0) bus.status_clr[i] = 2'($urandom_range(1, 3));
      end
      cycle();
      checks++; if (bus.tick_counter !== m_ticks || bus.tick_snapshot !== m_snap || bus.prescale_q !== 8'(m_div)) begin
        errors++; $display("FAIL rnd_global cyc=%0d tick=%0d/%0d snap=%0d/%0d div=%0d/%0d", c,
                           bus.tick_counter, m_ticks, bus.tick_snapshot, m_snap, bus.prescale_q, m_div); end
      checks++; if (bus.irq !== model_irq()) begin
        errors++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", c, bus.irq, model_irq()); end
      for (int i = 0; i < NT; i++) begin
        logic [7:0] ectrl;
        ectrl = {3'b000, m_iem[i], m_iee[i], 1'b0, m_auto[i], m_run[i]};
        checks++; if (bus.value_q[i] !== m_val[i] || bus.load_q[i] !== m_load[i] || bus.cmp_q[i] !== m_cmp[i] || bus.ctrl_q[i] !== ectrl) begin
          errors++; $display("FAIL rnd_regs cyc=%0d t=%0d value=%0d/%0d load=%0d/%0d cmp=%0d/%0d ctrl=%h/%h", c, i,
                             bus.value_q[i], m_val[i], bus.load_q[i], m_load[i], bus.cmp_q[i], m_cmp[i], bus.ctrl_q[i], ectrl); end
        checks++; if (bus.expired_q[i] !== m_exp[i] || bus.match_q[i] !== m_mat[i] || bus.expired_pulse[i] !== m_pulse[i]) begin
          errors++; $display("FAIL rnd_status cyc=%0d t=%0d exp=%b/%b match=%b/%b pulse=%b/%b", c, i,
                             bus.expired_q[i], m_exp[i], bus.match_q[i], m_mat[i], bus.expired_pulse[i], m_pulse[i]); end
      end
    end
  endtask

  initial begin
    bus.enable = 0;
    clear_strobes();
    bus.prescale_wdata = '0; bus.load_wdata = '0; bus.cmp_wdata = '0; bus.ctrl_wdata = '0;
    test_reset();
    test_tick_snapshot();
    test_prescale();
    test_autoreload();
    test_oneshot();
    test_match();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/carbonio_timer_bank.md
Name: carbonio_timer_bank

Overview:
Next-generation CarbonIO timer block. It provides a shared programmable prescaler, a free-running monotonic tick counter with an atomic snapshot latch, and NUM_TIMERS reloadable down-counters. Each down-counter has a compare/match flag, per-source interrupt enables and write-1-to-clear status. The block sits behind the CarbonIO register decoder, which drives the per-timer write strobes and reads the *_q outputs; irq feeds the CarbonIO interrupt aggregator.

Parameters:
NUM_TIMERS, 4, number of independent down-counter channels (1..16)
CNT_W, 32, width of load/compare/value registers
TICK_W, 64, width of monotonic tick counter and snapshot
PRESCALE_W, 8, width of shared prescaler divisor

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  global count enable; gates prescaler, tick counter and all timers
prescale_we  in  1  write strobe for prescaler divisor
prescale_wdata  in  PRESCALE_W  new divisor
prescale_q  out  PRESCALE_W  current divisor
tick_counter  out  TICK_W  monotonic tick count
snap_req  in  1  latch tick_counter into tick_snapshot
tick_snapshot  out  TICK_W  latched tick count
load_we  in  NUM_TIMERS  per-timer reload-value write strobe
load_wdata  in  [NUM_TIMERS][CNT_W]  reload value
cmp_we  in  NUM_TIMERS  per-timer compare write strobe
cmp_wdata  in  [NUM_TIMERS][CNT_W]  compare value
ctrl_we  in  NUM_TIMERS  per-timer control write strobe
ctrl_wdata  in  [NUM_TIMERS][7:0]  control write data
status_clr  in  [NUM_TIMERS][1:0]  W1C pulses: bit0 expired, bit1 match
load_q, cmp_q  out  [NUM_TIMERS][CNT_W]  stored reload / compare values
ctrl_q  out  [NUM_TIMERS][7:0]  stored control (bit2, bits7:5 always 0)
value_q  out  [NUM_TIMERS][CNT_W]  current count
expired_q, match_q  out  NUM_TIMERS  sticky status flags
expired_pulse  out  NUM_TIMERS  one-cycle pulse on expiry
irq  out  1  OR of enabled pending status

Behaviour:
- Reset: all registers and outputs 0, including pre_cnt, tick_counter, tick_snapshot, all per-timer state, pulses and irq.
- Prescaler: pre_cnt counts while enable. Internal tick strobe asserts in any enabled cycle with pre_cnt == prescale_q; pre_cnt then returns to 0. Divisor D gives one tick per D+1 enabled cycles; D=0 gives a tick every enabled cycle. prescale_we loads prescale_q, clears pre_cnt and suppresses tick in that cycle. enable low freezes pre_cnt.
- tick_counter increments by 1 on each tick and wraps modulo 2^TICK_W.
- snap_req captures the pre-increment tick_counter value into tick_snapshot at the next edge (1-cycle latency). It holds otherwise.
- ctrl bits: [0] run, [1] auto_reload, [2] reload_now (strobe, not stored), [3] ie_expired, [4] ie_match, [7:5] reserved (write ignored, read 0).
- Per-timer on tick with run=1:
  - If value_q==0: set expired_q and pulse expired_pulse for 1 cycle. With auto_reload, value_q<=load_q; otherwise run<=0 and value stays 0.
  - Otherwise value_q<=value_q-1. If additionally value_q==cmp_q, set match_q.
- Match against cmp_q==0 never fires; expiry covers that case.
- Priority per timer in one cycle:
  - ctrl_we with reload_now: value_q<=load value and the countdown step is skipped.
  - ctrl_we run/auto bits override the countdown's run clear.
  - load_we with reload_now in the same cycle: the reload uses load_wdata (forwarded), not the old load_q.
  - Status set beats status_clr in the same cycle.
- expired_pulse is 0 in every cycle without a fresh expiry.
- irq = OR over i of (expired_q[i]&ie_expired[i]) | (match_q[i]&ie_match[i]). It is combinational from flops only, with no added latency.
- Asserting rst_n low mid-count returns everything to reset values immediately. The first tick after release occurs after prescale+1 enabled cycles, counted from 0.

Test Plan:
- Reset, enable=1, prescale=0, 10 cycles -> tick_counter=10. snap_req at cycle 5 -> tick_snapshot=4 (pre-increment value) and holds.
- prescale=3, enable=1, 16 cycles -> tick_counter=4. Drop enable for 5 cycles -> tick_counter and pre_cnt frozen.
- Timer0 load=3, ctrl=0x0F (run, auto, reload_now, ie_expired), prescale=0 -> value 3,2,1,0. expired_pulse 1 cycle after value 0, then value reloads to 3; irq=1 until status_clr[0]=2'b01.
- Timer1 load=2, ctrl=0x05 (one-shot) -> expires once, ctrl_q[1][0] drops to 0, value stays 0, no further pulses.
- Timer2 load=10, cmp=6, ctrl=0x15 -> match_q[2] sets on the tick where value goes 6->5 and irq rises. status_clr issued on the same cycle as a new set -> flag remains 1.
- Same cycle: load_we=0x55 and ctrl_we reload_now on timer3 -> value_q[3]=0x55 next cycle, countdown skipped that cycle.
